// File: rtl/det_pkg.sv
// Shared state/opcode types, order constants and matrix index helpers for the
// sequential determinant engine.
package det_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_M2,
    S_M3,
    S_FIN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    MAC_HOLD,
    MAC_CLR,
    MAC_LOAD,
    MAC_ADD,
    MAC_SUB
  } mac_op_t;

  localparam logic [2:0] SZ2 = 3'd2;
  localparam logic [2:0] SZ3 = 3'd3;
  localparam logic [2:0] SZ4 = 3'd4;

  localparam int CYC_SZ2 = 2;
  localparam int CYC_SZ3 = 9;
  localparam int CYC_SZ4 = 28;

  // Element (r,c) sits row-major from the MSB of the packed matrix bus.
  function automatic int elem_lsb(input int r, input int c, input int ew);
    return (15 - 4 * r - c) * ew;
  endfunction

  function automatic logic size_legal(input logic [2:0] s);
    return (s == SZ2) || (s == SZ3) || (s == SZ4);
  endfunction

  // 2x2 minors are numbered by column pair: (0,1)(0,2)(0,3)(1,2)(1,3)(2,3).
  function automatic logic [2:0] pair_idx(input logic [1:0] i, input logic [1:0] j);
    case (i)
      2'd0:    pair_idx = {1'b0, j} - 3'd1;
      2'd1:    pair_idx = {1'b0, j} + 3'd1;
      default: pair_idx = 3'd5;
    endcase
  endfunction

  function automatic logic [1:0] pair_lo(input logic [2:0] p);
    case (p)
      3'd0, 3'd1, 3'd2: pair_lo = 2'd0;
      3'd3, 3'd4:       pair_lo = 2'd1;
      default:          pair_lo = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] pair_hi(input logic [2:0] p);
    case (p)
      3'd0:       pair_hi = 2'd1;
      3'd1, 3'd3: pair_hi = 2'd2;
      default:    pair_hi = 2'd3;
    endcase
  endfunction

  // n-th column left over once column k is struck out.
  function automatic logic [1:0] skip_col(input logic [1:0] k, input logic [1:0] n);
    return (n < k) ? n : n + 2'd1;
  endfunction

  // Every expansion starts positive and then alternates sign.
  function automatic mac_op_t term_op(input logic [1:0] step);
    if (step == 2'd0)
      return MAC_LOAD;
    else if (step[0])
      return MAC_SUB;
    else
      return MAC_ADD;
  endfunction

endpackage

// File: rtl/det_mac.sv
// Signed multiply-accumulate shared by every minor and the final row-0 expansion.
// acc_next is the value the accumulator takes on the coming edge.
module det_mac
  import det_pkg::*;
#(
  parameter int AW = 8,
  parameter int BW = 27,
  parameter int DW = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  mac_op_t              op,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [DW-1:0] acc_next
);

  localparam int PW = AW + BW;

  logic signed [DW-1:0] acc;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] prod_ext;

  assign prod     = PW'(a) * PW'(b);
  assign prod_ext = {{(DW - PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_next = acc;
    case (op)
      MAC_CLR:  acc_next = '0;
      MAC_LOAD: acc_next = prod_ext;
      MAC_ADD:  acc_next = acc + prod_ext;
      MAC_SUB:  acc_next = acc - prod_ext;
      default:  acc_next = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else
      acc <= acc_next;
  end

endmodule

// File: rtl/det_seq_nxn.sv
// Sequential determinant of a 2x2, 3x3 or 4x4 signed matrix by cofactor
// expansion: 2x2 minors, then 3x3 minors, then row 0, through one shared MAC.
module det_seq_nxn
  import det_pkg::*;
#(
  parameter int EW = 8,
  parameter int DW = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           size,
  input  logic [16*EW-1:0]     matrix,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] det,
  output logic                 err
);

  localparam int W2 = 2 * EW + 1;
  localparam int W3 = 3 * EW + 3;

  if (DW < 4 * EW + 5) begin : g_dw_check
    $error("det_seq_nxn: DW must be at least 4*EW+5");
  end

  state_t               state;
  logic [16*EW-1:0]     mat_q;
  logic [2:0]           ord_q;
  logic [2:0]           grp;
  logic [1:0]           step;
  logic signed [W2-1:0] m2_q [6];
  logic signed [W3-1:0] m3_q [4];
  logic signed [EW-1:0] a [4][4];

  mac_op_t              mac_op;
  logic signed [EW-1:0] op_a;
  logic signed [W3-1:0] op_b;
  logic signed [DW-1:0] acc_next;
  logic [2:0]           m2_pair;
  logic [2:0]           mp;
  logic [1:0]           rb;
  logic [1:0]           col;
  logic [1:0]           c0, c1, c2;
  logic                 fin_last;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign a[r][c] = mat_q[elem_lsb(r, c, EW) +: EW];
    end
  end

  function automatic logic signed [W3-1:0] sxe(input logic signed [EW-1:0] v);
    return {{(W3 - EW){v[EW-1]}}, v};
  endfunction

  function automatic logic signed [W3-1:0] sx2(input logic signed [W2-1:0] v);
    return {{(W3 - W2){v[W2-1]}}, v};
  endfunction

  // Order 3 only needs pairs (0,1),(0,2),(1,2), i.e. slots 0, 1 and 3.
  assign m2_pair  = (ord_q == SZ3 && grp == 3'd2) ? 3'd3 : grp;
  assign rb       = (ord_q == SZ4) ? 2'd2 : 2'd1;
  assign fin_last = (step == ord_q[1:0] - 2'd1);

  always_comb begin
    mac_op = MAC_HOLD;
    op_a   = '0;
    op_b   = '0;
    mp     = 3'd0;
    col    = 2'd0;
    c0     = 2'd0;
    c1     = 2'd0;
    c2     = 2'd0;
    case (state)
      S_LOAD: mac_op = MAC_CLR;
      S_M2: begin
        mac_op = term_op(step);
        if (step == 2'd0) begin
          op_a = a[rb][pair_lo(m2_pair)];
          op_b = sxe(a[rb + 2'd1][pair_hi(m2_pair)]);
        end else begin
          op_a = a[rb][pair_hi(m2_pair)];
          op_b = sxe(a[rb + 2'd1][pair_lo(m2_pair)]);
        end
      end
      S_M3: begin
        mac_op = term_op(step);
        c0 = skip_col(grp[1:0], 2'd0);
        c1 = skip_col(grp[1:0], 2'd1);
        c2 = skip_col(grp[1:0], 2'd2);
        case (step)
          2'd0: begin col = c0; mp = pair_idx(c1, c2); end
          2'd1: begin col = c1; mp = pair_idx(c0, c2); end
          default: begin col = c2; mp = pair_idx(c0, c1); end
        endcase
        op_a = a[1][col];
        op_b = sx2(m2_q[mp]);
      end
      S_FIN: begin
        mac_op = term_op(step);
        op_a   = a[0][step];
        c0 = skip_col(step, 2'd0);
        c1 = skip_col(step, 2'd1);
        mp = pair_idx(c0, c1);
        if (ord_q == SZ4)
          op_b = m3_q[step];
        else if (ord_q == SZ3)
          op_b = sx2(m2_q[mp]);
        else
          op_b = sxe(a[1][{1'b0, ~step[0]}]);
      end
      default: mac_op = MAC_HOLD;
    endcase
  end

  det_mac #(
    .AW(EW),
    .BW(W3),
    .DW(DW)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (mac_op),
    .a        (op_a),
    .b        (op_b),
    .acc_next (acc_next)
  );

  // An illegal order idles one cycle in LOAD so its result lands at T0+2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      det   <= '0;
      err   <= 1'b0;
      mat_q <= '0;
      ord_q <= '0;
      grp   <= '0;
      step  <= '0;
      for (int i = 0; i < 6; i++) m2_q[i] <= '0;
      for (int i = 0; i < 4; i++) m3_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mat_q <= matrix;
            ord_q <= size;
            busy  <= 1'b1;
            grp   <= '0;
            step  <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!size_legal(ord_q)) begin
            if (step == 2'd0) begin
              step <= 2'd1;
            end else begin
              step  <= '0;
              det   <= '0;
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
          end else begin
            step  <= '0;
            grp   <= '0;
            state <= (ord_q == SZ2) ? S_FIN : S_M2;
          end
        end
        S_M2: begin
          if (step == 2'd1) begin
            m2_q[m2_pair] <= acc_next[W2-1:0];
            step <= '0;
            if (grp == ((ord_q == SZ4) ? 3'd5 : 3'd2)) begin
              grp   <= '0;
              state <= (ord_q == SZ4) ? S_M3 : S_FIN;
            end else begin
              grp <= grp + 3'd1;
            end
          end else begin
            step <= step + 2'd1;
          end
        end
        S_M3: begin
          if (step == 2'd2) begin
            m3_q[grp[1:0]] <= acc_next[W3-1:0];
            step <= '0;
            if (grp == 3'd3) begin
              grp   <= '0;
              state <= S_FIN;
            end else begin
              grp <= grp + 3'd1;
            end
          end else begin
            step <= step + 2'd1;
          end
        end
        S_FIN: begin
          if (fin_last) begin
            det   <= acc_next;
            err   <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            step  <= '0;
            state <= S_DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_det_seq_nxn.sv
// Directed bench for det_seq_nxn: hand-computed determinants, result latency,
// illegal orders, busy-time start filtering and mid-run reset.
module tb_det_seq_nxn;

  localparam int EW = 8;
  localparam int DW = 40;

  logic                 clk    = 1'b0;
  logic                 rst_n  = 1'b1;
  logic                 start  = 1'b0;
  logic [2:0]           size   = '0;
  logic [16*EW-1:0]     matrix = '0;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic signed [DW-1:0] det;

  int total   = 0;
  int bad     = 0;
  int cyc_cnt = 0;
  int t0      = 0;
  int seen    = 0;

  int mat_a    [16] = '{1, 0, 2, -1,  3, 0, 0, 5,  2, 1, 4, -3,  1, 0, 5, 0};
  int mat_diag [16] = '{-128, 0, 0, 0,  0, -128, 0, 0,  0, 0, -128, 0,  0, 0, 0, -128};
  int mat_neg  [16] = '{-128, -128, -128, -128,  -128, -128, -128, -128,
                        -128, -128, -128, -128,  -128, -128, -128, -128};
  int mat_b    [16] = '{3, 7, 9, 9,  -2, 5, 9, 9,  9, 9, 9, 9,  9, 9, 9, 9};
  int mat_c    [16] = '{2, -1, 0, 7,  1, 3, 4, 7,  0, 5, -2, 7,  7, 7, 7, 7};

  det_seq_nxn #(
    .EW(EW),
    .DW(DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .size   (size),
    .matrix (matrix),
    .busy   (busy),
    .done   (done),
    .det    (det),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [16*EW-1:0] pk(input int e [16]);
    logic [16*EW-1:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[(15 - i) * EW +: EW] = e[i][EW-1:0];
    return v;
  endfunction

  task automatic check_output(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [16*EW-1:0] m, input logic [2:0] s);
    @(negedge clk);
    matrix = m;
    size   = s;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc_cnt;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    while (done !== 1'b1 && (cyc_cnt - t0) < 60) begin
      @(posedge clk);
      #1;
    end
    check_output({tag, "_cyc"}, cyc_cnt - t0, exp_cyc);
  endtask

  task automatic finish_check(input string tag, input longint exp_det,
                              input logic exp_err, input int exp_cyc);
    wait_done(tag, exp_cyc);
    check_output({tag, "_det"}, det, exp_det);
    check_output({tag, "_err"}, err, exp_err);
    check_output({tag, "_busy_lo"}, busy, 0);
    @(posedge clk);
    #1;
    check_output({tag, "_done_lo"}, done, 0);
    check_output({tag, "_det_hold"}, det, exp_det);
  endtask

  task automatic run_check(input string tag, input logic [16*EW-1:0] m, input logic [2:0] s,
                           input longint exp_det, input logic exp_err, input int exp_cyc);
    apply_stimulus(m, s);
    check_output({tag, "_busy_hi"}, busy, 1);
    finish_check(tag, exp_det, exp_err, exp_cyc);
  endtask

  initial begin
    $display("[TB] det_seq_nxn directed test");
    #2 rst_n = 1'b0;
    #10;
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_det", det, 0);
    check_output("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_check("a4", pk(mat_a), 3'd4, 30, 1'b0, 29);
    run_check("a3", pk(mat_a), 3'd3, 6, 1'b0, 10);
    run_check("a2", pk(mat_a), 3'd2, 0, 1'b0, 3);
    run_check("diag4", pk(mat_diag), 3'd4, 268435456, 1'b0, 29);
    run_check("neg4", pk(mat_neg), 3'd4, 0, 1'b0, 29);
    run_check("c3", pk(mat_c), 3'd3, -54, 1'b0, 10);

    run_check("bad5", pk(mat_a), 3'd5, 0, 1'b1, 2);
    run_check("b2", pk(mat_b), 3'd2, 29, 1'b0, 3);
    run_check("bad0", pk(mat_c), 3'd0, 0, 1'b1, 2);
    run_check("c3b", pk(mat_c), 3'd3, -54, 1'b0, 10);

    // start during a run and input changes after accept must not matter
    apply_stimulus(pk(mat_a), 3'd4);
    matrix = pk(mat_diag);
    size   = 3'd2;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("ign_busy_hi", busy, 1);
    finish_check("ign", 30, 1'b0, 29);
    repeat (3) @(posedge clk);
    #1;
    check_output("ign_noqueue", busy, 0);

    // start held high: second accept once the FSM is back in IDLE
    @(negedge clk);
    matrix = pk(mat_b);
    size   = 3'd2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc_cnt;
    wait_done("hold1", 3);
    check_output("hold1_det", det, 29);
    t0 = cyc_cnt;
    @(posedge clk);
    #1;
    wait_done("hold2", 5);
    start = 1'b0;
    check_output("hold2_det", det, 29);
    check_output("hold2_busy_lo", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_output("hold_stop", busy, 0);

    // reset in the middle of a run
    apply_stimulus(pk(mat_diag), 3'd4);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_done", done, 0);
    check_output("mid_rst_det", det, 0);
    check_output("mid_rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    check_output("mid_rst_no_done", seen, 0);
    check_output("mid_rst_idle", busy, 0);

    // accept on the very first rising edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    matrix = pk(mat_c);
    size   = 3'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc_cnt;
    check_output("post_rst_busy_hi", busy, 1);
    finish_check("post_rst", -54, 1'b0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/det_seq_nxn.md
DET_SEQ_NXN -- requirements
Module: det_seq_nxn

Interface
REQ-001 SHALL have parameter EW, default 8: signed element width in bits.
REQ-002 SHALL have parameter DW, default 40: signed result width; DW >= 4*EW+5 is checked at elaboration, and a smaller DW is an elaboration error.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-006 SHALL have port size  input  3  matrix order, legal values 2, 3, 4; sampled at accept.
REQ-007 SHALL have port matrix  input  16*EW  elements (r,c) packed row-major from the MSB.
- Element (r,c) occupies bits [(16-4r-c)*EW-1 -: EW], so (0,0) is the MSB field.
- Orders 2 and 3 use the top-left submatrix; all other fields are ignored.
REQ-008 SHALL have port busy  output  1  high while a computation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port det  output  DW  signed determinant; held until the next accept.
REQ-011 SHALL have port err  output  1  set when an illegal size was accepted; held like det.

Function
REQ-012 SHALL register matrix and size on the accept edge T0 (start=1 in IDLE).
- Input changes after T0 SHALL NOT affect the result.
REQ-013 SHALL compute with exactly one signed EW-by-wide multiplier and one add/sub accumulator, one product per cycle.
REQ-014 SHALL use the FSM IDLE -> LOAD -> M2 -> M3 -> FIN -> DONE -> IDLE; states not needed for the accepted order are skipped.
REQ-015 M2: for order 4, SHALL form the six 2x2 minors of rows 2-3 (12 cycles); for order 3, the three 2x2 minors of rows 1-2 (6 cycles).
REQ-016 M3: for order 4 only, SHALL form the four 3x3 minors of rows 1-3 by alternating-sign expansion on row 1 (12 cycles).
REQ-017 FIN: SHALL expand along row 0 with signs +,-,+,- into the DW accumulator (order 4: 4 cycles, order 3: 3 cycles, order 2: 2 cycles).
REQ-018 SHALL keep intermediates without overflow: 2x2 minors at 2*EW+1 bits, 3x3 minors at 3*EW+3 bits, final sign-extended to DW.
REQ-019 Compute cycles C SHALL be 28 for order 4, 9 for order 3 and 2 for order 2.
- done SHALL rise on edge T0+C+1 and fall one edge later.
- det and err SHALL update on the edge that raises done.
REQ-020 busy SHALL rise on T0 and fall on the edge that raises done.
REQ-021 start while busy or done is high SHALL be ignored and SHALL NOT be queued.
REQ-022 start held high continuously SHALL begin a new computation on the first edge at which the FSM is in IDLE.
REQ-023 An illegal size (0, 1, 5-7) SHALL go LOAD -> DONE, giving done at T0+2, err=1 and det=0.
REQ-024 A legal computation SHALL clear err.

Reset
REQ-025 rst_n low SHALL immediately force: FSM=IDLE, busy=0, done=0, det=0, err=0, accumulator and minor storage cleared.
REQ-026 Reset asserted mid-computation SHALL abort it with no done pulse.
REQ-027 After release, the first accept SHALL be possible on the first rising edge at which rst_n is high.

Structure
REQ-028 A shared package det_pkg SHALL hold:
- the FSM state enum;
- the size constants SZ2, SZ3, SZ4;
- the per-order cycle-count constants 2, 9, 28;
- the element-index function (r,c) -> bit offset.
REQ-029 SHALL instantiate one sub-module det_mac.
- det_mac is a registered signed multiply with add/subtract/clear control.
- The FSM, operand-select counters and minor register file stay in det_seq_nxn.

Verification
REQ-030 Order 4, rows {1,0,2,-1},{3,0,0,5},{2,1,4,-3},{1,0,5,0} -> det=30, err=0, done exactly 29 cycles after the accept edge.
REQ-031 Same matrix with size=3 -> det=6 at T0+10; with size=2 -> det=0 at T0+3.
REQ-032 Order 4, diagonal of -128 with zeros elsewhere -> det=268435456 with no overflow; all elements -128 -> det=0.
REQ-033 size=5 -> err=1, det=0, done at T0+2; a following legal run clears err.
REQ-034 start pulsed at T0+5 while busy, and the matrix changed after T0 -> ignored, original result returned; rst_n pulsed low at T0+10 -> outputs zero, no done, and the next run is correct.
